// File: rtl/my_dmaster_pkg.sv
// Shared types and constants for the my_dmaster Avalon-MM write master.
package my_dmaster_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

  localparam int SENT_W = 16;

  // Counter width that holds GAP_CYCLES-1, never narrower than one bit.
  function automatic int gap_width(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/my_gap_timer.sv
// Loadable down-counter that times the idle gap between writes.
module my_gap_timer #(
  parameter int W = 2
) (
  input  logic         csi_clk,
  input  logic         rsi_reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/my_dmaster.sv
// Avalon-MM write master: issues N_WRITES single-beat writes per start, GAP_CYCLES apart.
module my_dmaster
  import my_dmaster_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int BASE_ADDR  = 0,
  parameter int N_WRITES   = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_write,
  output logic [DATA_W-1:0] avm_m0_writedata,
  input  logic              avm_m0_waitrequest,
  input  logic              coe_m0_start,
  input  logic              coe_m0_abort,
  output logic              coe_m0_busy,
  output logic              coe_m0_done,
  output logic [SENT_W-1:0] coe_m0_sent,
  output logic [1:0]        dbg_state
);

  localparam int                GAP_W    = gap_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SENT_W-1:0] LAST_IDX = SENT_W'(N_WRITES - 1);

  state_t            state;
  logic [SENT_W-1:0] index;
  logic              abort_pend;
  logic              abort_now;
  logic              last_write;
  logic              gap_load;
  logic              gap_enable;
  logic              gap_zero;

  // Handshake: a write transfers on a rising edge where avm_m0_write=1 and
  // avm_m0_waitrequest=0; while stalled, address/write/writedata stay frozen.
  assign abort_now  = abort_pend | coe_m0_abort;
  assign last_write = (index == LAST_IDX);
  assign gap_load   = (state == WRITE) && !avm_m0_waitrequest && !last_write &&
                      !abort_now && (GAP_CYCLES != 0);
  assign gap_enable = (state == GAP);

  assign avm_m0_address = ADDR_W'(BASE_ADDR);
  assign dbg_state      = state;

  my_gap_timer #(.W(GAP_W)) u_gap_timer (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .load      (gap_load),
    .value     (GAP_LOAD),
    .enable    (gap_enable),
    .zero      (gap_zero)
  );

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state            <= IDLE;
      index            <= '0;
      abort_pend       <= 1'b0;
      avm_m0_write     <= 1'b0;
      avm_m0_writedata <= '0;
      coe_m0_busy      <= 1'b0;
      coe_m0_done      <= 1'b0;
      coe_m0_sent      <= '0;
    end else begin
      coe_m0_done <= 1'b0;
      if ((state != IDLE) && coe_m0_abort) begin
        abort_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (coe_m0_start) begin
            state            <= WRITE;
            index            <= '0;
            avm_m0_write     <= 1'b1;
            avm_m0_writedata <= '0;
            coe_m0_busy      <= 1'b1;
          end
        end
        WRITE: begin
          // Nothing moves until the slave releases waitrequest.
          if (!avm_m0_waitrequest) begin
            coe_m0_sent      <= coe_m0_sent + 1'b1;
            index            <= index + 1'b1;
            avm_m0_writedata <= DATA_W'(index + 1'b1);
            if (last_write || abort_now) begin
              state        <= DONE;
              avm_m0_write <= 1'b0;
              coe_m0_done  <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              state <= WRITE;
            end else begin
              state        <= GAP;
              avm_m0_write <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_zero) begin
            if (abort_now) begin
              state       <= DONE;
              coe_m0_done <= 1'b1;
            end else begin
              state        <= WRITE;
              avm_m0_write <= 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          coe_m0_busy <= 1'b0;
          abort_pend  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_dmaster.sv
// Bench for my_dmaster: two configurations, scoreboard of expected transfers/done pulses.
module tb_my_dmaster;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  localparam int N_OF [2] = '{16, 4};
  localparam int G_OF [2] = '{4, 0};
  localparam int B_OF [2] = '{0, 5};

  // Point-check selectors
  localparam logic [2:0] S_WRITE = 3'd0, S_BUSY = 3'd1, S_DONE = 3'd2,
                         S_SENT = 3'd3, S_SLV = 3'd4, S_WDATA = 3'd5;

  typedef struct packed {
    logic        is_done;
    logic        inst;
    logic [15:0] val;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        inst;
    logic [2:0]  sel;
    logic [15:0] val;
  } pt_t;

  // ---------------- clock / reset ----------------
  logic csi_clk = 1'b0;
  always #5 csi_clk = ~csi_clk;
  logic rsi_reset;
  int   cyc = 0;
  always @(posedge csi_clk) cyc <= cyc + 1;

  logic          start_s [2];
  logic          abort_s [2];
  logic          wait_s  [2];
  logic          write_s [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic [DW-1:0] wdata_s [2];
  logic [AW-1:0] addr_s  [2];
  logic [15:0]   sent_s  [2];
  logic [1:0]    dbg_s   [2];

  my_dmaster #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .N_WRITES(16), .GAP_CYCLES(4)) dut_a (
    .csi_clk(csi_clk), .rsi_reset(rsi_reset),
    .avm_m0_address(addr_s[0]), .avm_m0_write(write_s[0]), .avm_m0_writedata(wdata_s[0]),
    .avm_m0_waitrequest(wait_s[0]), .coe_m0_start(start_s[0]), .coe_m0_abort(abort_s[0]),
    .coe_m0_busy(busy_s[0]), .coe_m0_done(done_s[0]), .coe_m0_sent(sent_s[0]),
    .dbg_state(dbg_s[0])
  );

  my_dmaster #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(5), .N_WRITES(4), .GAP_CYCLES(0)) dut_b (
    .csi_clk(csi_clk), .rsi_reset(rsi_reset),
    .avm_m0_address(addr_s[1]), .avm_m0_write(write_s[1]), .avm_m0_writedata(wdata_s[1]),
    .avm_m0_waitrequest(wait_s[1]), .coe_m0_start(start_s[1]), .coe_m0_abort(abort_s[1]),
    .coe_m0_busy(busy_s[1]), .coe_m0_done(done_s[1]), .coe_m0_sent(sent_s[1]),
    .dbg_state(dbg_s[1])
  );

  // ---------------- scoreboard state ----------------
  exp_t        exp_q [$];
  pt_t         pt_q  [$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] sent_m [2];
  int          timeouts = 0;
  logic        end_req  = 1'b0;

  // waitrequest modes: 0 never stall, 1 random, 2 stall inside [win_lo, win_hi]
  int wmode [2];
  int win_lo = 0;
  int win_hi = -1;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge csi_clk);
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic push_pt(input int c, input int g, input logic [2:0] sel, input int v);
    pt_q.push_back('{cyc: 32'(c), inst: g[0], sel: sel, val: 16'(v)});
  endtask

  // Expected transfers of one run: write j carries j mod 2^DW, spaced 1+gap cycles,
  // with every write from index sj onwards delayed by an sl-cycle stall.
  task automatic push_run(input int g, input int c, input int n, input int gap,
                          input int sj, input int sl, input int done_off,
                          input bit has_done, input bit timed);
    int t;
    int last;
    t = c + 1;
    last = t;
    for (int j = 0; j < n; j++) begin
      if (j == sj) t += sl;
      exp_q.push_back('{is_done: 1'b0, inst: g[0], val: 16'(j % (1 << DW)),
                        cyc: timed ? 32'(t) : NONE});
      last = t;
      t += 1 + gap;
    end
    sent_m[g] = sent_m[g] + 16'(n);
    if (has_done)
      exp_q.push_back('{is_done: 1'b1, inst: g[0], val: sent_m[g],
                        cyc: timed ? 32'(last + done_off) : NONE});
  endtask

  task automatic do_reset();
    int c;
    step();
    rsi_reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      abort_s[g] = 1'b0;
      wmode[g]   = 0;
    end
    c = cyc;
    for (int g = 0; g < 2; g++) begin
      push_pt(c + 1, g, S_WRITE, 0);
      push_pt(c + 1, g, S_BUSY, 0);
      push_pt(c + 1, g, S_DONE, 0);
      push_pt(c + 1, g, S_SENT, 0);
      push_pt(c + 1, g, S_WDATA, 0);
    end
    step();
    step();
    rsi_reset = 1'b0;
    sent_m[0] = '0;
    sent_m[1] = '0;
  endtask

  task automatic wait_idle(input int g);
    int k;
    k = 0;
    while (busy_s[g] && k < 3000) begin
      step();
      k++;
    end
    if (k >= 3000) timeouts++;
  endtask

  // ---------------- waitrequest driver ----------------
  initial begin
    wait_s[0] = 1'b0;
    wait_s[1] = 1'b0;
    forever begin
      @(posedge csi_clk);
      #2;
      for (int g = 0; g < 2; g++) begin
        case (wmode[g])
          1:       wait_s[g] = ($urandom_range(0, 2) == 0);
          2:       wait_s[g] = (cyc >= win_lo) && (cyc <= win_hi);
          default: wait_s[g] = 1'b0;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] get_act(input logic g, input logic [2:0] sel);
    case (sel)
      S_WRITE: return 16'(write_s[g]);
      S_BUSY:  return 16'(busy_s[g]);
      S_DONE:  return 16'(done_s[g]);
      S_SENT:  return sent_s[g];
      S_WDATA: return 16'(wdata_s[g]);
      default: return 16'hDEAD;
    endcase
  endfunction

  initial begin
    exp_t          e;
    pt_t           p;
    logic          hold_v [2];
    logic [DW-1:0] hold_d [2];
    logic [AW-1:0] hold_a [2];
    int            slv_cnt [2];
    hold_v  = '{1'b0, 1'b0};
    slv_cnt = '{0, 0};
    forever begin
      @(negedge csi_clk);
      if (rsi_reset) begin
        hold_v  = '{1'b0, 1'b0};
        slv_cnt = '{0, 0};
      end
      while (pt_q.size() > 0 && pt_q[0].cyc <= 32'(cyc)) begin
        p = pt_q.pop_front();
        if (p.sel == S_SLV) chk("slave_count", 32'(slv_cnt[p.inst]), 32'(p.val));
        else                chk($sformatf("point_sel%0d_inst%0d", p.sel, p.inst),
                                32'(get_act(p.inst, p.sel)), 32'(p.val));
      end
      if (!rsi_reset) begin
        for (int g = 0; g < 2; g++) begin
          if (hold_v[g]) begin
            chk("stall_write_held", 32'(write_s[g]), 32'd1);
            chk("stall_wdata_held", 32'(wdata_s[g]), 32'(hold_d[g]));
            chk("stall_addr_held", 32'(addr_s[g]), 32'(hold_a[g]));
          end
          hold_v[g] = write_s[g] && wait_s[g];
          hold_d[g] = wdata_s[g];
          hold_a[g] = addr_s[g];
          if (write_s[g] && !wait_s[g]) begin
            slv_cnt[g]++;
            chk("address", 32'(addr_s[g]), 32'(B_OF[g]));
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_write inst=%0d cyc=%0d actual=%0d expected=none",
                       g, cyc, wdata_s[g]);
            end else begin
              e = exp_q.pop_front();
              chk("xfer_kind", 32'(e.is_done), 32'd0);
              chk("xfer_inst", 32'(e.inst), 32'(g));
              chk("xfer_wdata", 32'(wdata_s[g]), 32'(e.val));
              if (e.cyc != NONE) chk("xfer_cycle", 32'(cyc), e.cyc);
            end
          end
          if (done_s[g]) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_done inst=%0d cyc=%0d actual=1 expected=0", g, cyc);
            end else begin
              e = exp_q.pop_front();
              chk("done_kind", 32'(e.is_done), 32'd1);
              chk("done_inst", 32'(e.inst), 32'(g));
              chk("done_sent", 32'(sent_s[g]), 32'(e.val));
              if (e.cyc != NONE) chk("done_cycle", 32'(cyc), e.cyc);
            end
          end
        end
      end
      if (end_req || cyc > 60000) begin
        chk("watchdog", 32'(cyc > 60000), 32'd0);
        chk("wait_timeouts", 32'(timeouts), 32'd0);
        chk("exp_q_left", 32'(exp_q.size()), 32'd0);
        chk("pt_q_left", 32'(pt_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int g;
    rsi_reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      wmode[i]   = 0;
      sent_m[i]  = '0;
    end
    do_reset();

    // Plain run with default parameters
    step();
    c = cyc;
    start_s[0] = 1'b1;
    push_run(0, c, 16, 4, -1, 0, 1, 1'b1, 1'b1);
    push_pt(c + 1, 0, S_BUSY, 1);
    push_pt(c + 77, 0, S_BUSY, 1);
    push_pt(c + 78, 0, S_BUSY, 0);
    push_pt(c + 78, 0, S_SENT, 16);
    push_pt(c + 79, 0, S_SLV, 16);
    step();
    start_s[0] = 1'b0;
    step_to(c + 85);

    // Three-cycle stall on the second write
    do_reset();
    step();
    c = cyc;
    win_lo = c + 6;
    win_hi = c + 8;
    wmode[0] = 2;
    start_s[0] = 1'b1;
    push_run(0, c, 16, 4, 1, 3, 1, 1'b1, 1'b1);
    push_pt(c + 81, 0, S_SENT, 16);
    step();
    start_s[0] = 1'b0;
    step_to(c + 90);
    wmode[0] = 0;

    // Abort while the third write is stalled
    do_reset();
    step();
    c = cyc;
    win_lo = c + 11;
    win_hi = c + 12;
    wmode[0] = 2;
    start_s[0] = 1'b1;
    push_run(0, c, 3, 4, 2, 2, 1, 1'b1, 1'b1);
    push_pt(c + 14, 0, S_BUSY, 1);
    push_pt(c + 15, 0, S_BUSY, 0);
    push_pt(c + 16, 0, S_SENT, 3);
    step();
    start_s[0] = 1'b0;
    step_to(c + 11);
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    step_to(c + 20);
    wmode[0] = 0;

    // Abort during a gap ends the run at the end of that gap
    step();
    c = cyc;
    start_s[0] = 1'b1;
    push_run(0, c, 2, 4, -1, 0, 5, 1'b1, 1'b1);
    push_pt(c + 12, 0, S_BUSY, 0);
    step();
    start_s[0] = 1'b0;
    step_to(c + 8);
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    step_to(c + 20);

    // Reset in the gap after five writes, then a full run
    do_reset();
    step();
    c = cyc;
    start_s[0] = 1'b1;
    push_run(0, c, 5, 4, -1, 0, 1, 1'b0, 1'b1);
    step();
    start_s[0] = 1'b0;
    step_to(c + 23);
    rsi_reset = 1'b1;
    push_pt(c + 24, 0, S_WRITE, 0);
    push_pt(c + 24, 0, S_BUSY, 0);
    push_pt(c + 24, 0, S_SENT, 0);
    step();
    rsi_reset = 1'b0;
    sent_m[0] = '0;
    step();
    c = cyc;
    start_s[0] = 1'b1;
    push_run(0, c, 16, 4, -1, 0, 1, 1'b1, 1'b1);
    push_pt(c + 80, 0, S_SENT, 16);
    step();
    start_s[0] = 1'b0;
    step_to(c + 85);

    // Back-to-back configuration; abort in IDLE and abort together with start are ignored
    do_reset();
    step();
    abort_s[1] = 1'b1;
    step();
    abort_s[1] = 1'b0;
    step();
    c = cyc;
    start_s[1] = 1'b1;
    abort_s[1] = 1'b1;
    push_run(1, c, 4, 0, -1, 0, 1, 1'b1, 1'b1);
    push_pt(c + 5, 1, S_WRITE, 0);
    push_pt(c + 6, 1, S_BUSY, 0);
    step();
    start_s[1] = 1'b0;
    abort_s[1] = 1'b0;
    step_to(c + 10);

    // Start held for two runs, then a start pulse while busy
    do_reset();
    step();
    c = cyc;
    start_s[0] = 1'b1;
    push_run(0, c, 16, 4, -1, 0, 1, 1'b1, 1'b1);
    push_run(0, c + 78, 16, 4, -1, 0, 1, 1'b1, 1'b1);
    push_pt(c + 157, 0, S_SENT, 32);
    push_pt(c + 157, 0, S_BUSY, 0);
    step_to(c + 79);
    start_s[0] = 1'b0;
    step_to(c + 100);
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    step_to(c + 175);

    // Random waitrequest on both configurations
    wmode[0] = 1;
    wmode[1] = 1;
    for (int r = 0; r < 6; r++) begin
      g = r % 2;
      repeat ($urandom_range(1, 5)) step();
      c = cyc;
      start_s[g] = 1'b1;
      push_run(g, c, N_OF[g], G_OF[g], -1, 0, 1, 1'b1, 1'b0);
      step();
      start_s[g] = 1'b0;
      wait_idle(g);
    end
    wmode[0] = 0;
    wmode[1] = 0;
    repeat (5) step();
    end_req = 1'b1;
    forever step();
  end

endmodule
